frame_line_reader: RTL and testbench

FRAME_LINE_READER -- requirements
Module: frame_line_reader

---
 rtl/frame_pkg.sv | 26 ++
 rtl/line_buffer_pp.sv | 40 ++++
 rtl/frame_line_reader.sv | 208 ++++++++++++++++++++
 tb/tb_frame_line_reader.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// ---------------------------------------------------------------------------
// frame_pkg : shared image-window geometry, SPRAM address width, fetch FSM
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package frame_pkg;

  localparam int FRAME_W         = 200;
  localparam int FRAME_H         = 150;
  localparam int FRAME_ROW_START = 224;
  localparam int FRAME_COL_START = 300;
  localparam logic [11:0] FRAME_BG_COLOR = 12'h000;
  localparam int ADDR_W          = 15;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PREFETCH  = 3'd1,
    ST_WAIT_LINE = 3'd2,
    ST_FETCH     = 3'd3,
    ST_DONE      = 3'd4
  } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/line_buffer_pp.sv
// ---------------------------------------------------------------------------
// line_buffer_pp : ping-pong pair of W x DATA_W line buffers, 1W / 1R (registered)
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module line_buffer_pp #(
  parameter int W      = 200,
  parameter int DATA_W = 12,
  parameter int COL_W  = $clog2(W)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic              wr_bank,
  input  logic [COL_W-1:0]  wr_col,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic              rd_bank,
  input  logic [COL_W-1:0]  rd_col,
  output logic [DATA_W-1:0] rd_data
);

  // Bank bit on top of the column keeps both buffers in one block RAM.
  logic [DATA_W-1:0] mem_q [2**(COL_W+1)];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[{wr_bank, wr_col}] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem_q[{rd_bank, rd_col}];
    end
  end

  assign rd_data = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/frame_line_reader.sv
// ---------------------------------------------------------------------------
// frame_line_reader : streams image rows from SPRAM into ping-pong line buffers
//                     and serves display pixels for a fixed window
// Revision          : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module frame_line_reader
  import frame_pkg::*;
#(
  parameter int          W         = FRAME_W,
  parameter int          H         = FRAME_H,
  parameter int          ROW_START = FRAME_ROW_START,
  parameter int          COL_START = FRAME_COL_START,
  parameter logic [11:0] BG_COLOR  = FRAME_BG_COLOR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              image_complete,
  input  logic              frame_start,
  input  logic [9:0]        x_addr,
  input  logic [9:0]        y_addr,
  output logic [ADDR_W-1:0] spram_addr,
  output logic              spram_rd_en,
  input  logic [11:0]       spram_rd_data,
  output logic [11:0]       pixel_data,
  output logic              line_ready,
  output logic              underrun,
  output logic              busy
);

  localparam int COL_W = $clog2(W);
  localparam int ROW_W = $clog2(H);
  localparam logic [10:0] ROW_LO = 11'(ROW_START);
  localparam logic [10:0] ROW_HI = 11'(ROW_START + H);
  localparam logic [10:0] COL_LO = 11'(COL_START);
  localparam logic [10:0] COL_HI = 11'(COL_START + W);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(W - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(H - 1);

  fetch_state_e state_q, state_d;
  logic                    rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [COL_W-1:0]        iss_col_q, iss_col_d;
  logic                    wr_en_q, wr_en_d;
  logic [COL_W-1:0]        wr_col_q, wr_col_d;
  logic [ROW_W-1:0]        fill_row_q, fill_row_d, next_row;
  logic [1:0]              valid_q, valid_d;
  logic [1:0][ROW_W-1:0]   tag_q, tag_d;
  logic [9:0]              y_prev_q;
  logic                    row_bg_q, row_bg_d;
  logic                    underrun_q, underrun_d;
  logic                    pix_sel_q, pix_sel_d;
  logic                    line_ready_q, line_ready_d;

  logic [10:0]      y_ext, x_ext;
  logic             in_rows, in_cols, in_win;
  logic [ROW_W-1:0] disp_row;
  logic [COL_W-1:0] disp_col;
  logic             disp_bank, row_valid, y_changed, row_bg_now, wait_hit;
  logic             buf_rd_en;
  logic [11:0]      buf_rd_data;

  assign y_ext     = {1'b0, y_addr};
  assign x_ext     = {1'b0, x_addr};
  assign in_rows   = (y_ext >= ROW_LO) && (y_ext < ROW_HI);
  assign in_cols   = (x_ext >= COL_LO) && (x_ext < COL_HI);
  assign in_win    = in_rows && in_cols;
  assign disp_row  = y_addr[ROW_W-1:0] - ROW_LO[ROW_W-1:0];
  assign disp_col  = x_addr[COL_W-1:0] - COL_LO[COL_W-1:0];
  assign disp_bank = disp_row[0];
  // The tag check stops a stale buffer from an older row posing as the current one.
  assign row_valid = valid_q[disp_bank] && (tag_q[disp_bank] == disp_row);
  assign y_changed = (y_addr != y_prev_q);
  assign row_bg_now = y_changed ? !row_valid : row_bg_q;
  assign wait_hit  = (y_ext == (ROW_LO + 11'(fill_row_q)));
  assign next_row  = fill_row_q + 1'b1;
  assign buf_rd_en = in_win && row_valid;

  always_comb begin
    state_d      = state_q;
    rd_en_d      = rd_en_q;
    addr_d       = addr_q;
    iss_col_d    = iss_col_q;
    wr_en_d      = rd_en_q;
    wr_col_d     = iss_col_q;
    fill_row_d   = fill_row_q;
    valid_d      = valid_q;
    tag_d        = tag_q;
    row_bg_d     = row_bg_now;
    underrun_d   = underrun_q | (y_changed && in_rows && !row_valid);
    pix_sel_d    = in_win && row_valid && !row_bg_now;
    line_ready_d = in_win && row_valid;

    if (rd_en_q) begin
      addr_d = addr_q + 1'b1;
      if (iss_col_q == LAST_COL) begin
        rd_en_d = 1'b0;
      end else begin
        iss_col_d = iss_col_q + 1'b1;
      end
    end

    case (state_q)
      ST_PREFETCH, ST_FETCH: begin
        if (wr_en_q && (wr_col_q == LAST_COL)) begin
          valid_d[fill_row_q[0]] = 1'b1;
          state_d                = ST_WAIT_LINE;
        end
      end
      ST_WAIT_LINE: begin
        if (wait_hit) begin
          if (fill_row_q != LAST_ROW) begin
            fill_row_d           = next_row;
            state_d              = ST_FETCH;
            rd_en_d              = 1'b1;
            iss_col_d            = '0;
            valid_d[next_row[0]] = 1'b0;
            tag_d[next_row[0]]   = next_row;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      default: begin
      end
    endcase

    if (frame_start) begin
      valid_d    = 2'b00;
      wr_en_d    = 1'b0;
      underrun_d = 1'b0;
      state_d    = ST_PREFETCH;
      rd_en_d    = 1'b1;
      addr_d     = '0;
      iss_col_d  = '0;
      fill_row_d = '0;
      tag_d[0]   = '0;
    end

    if (!image_complete) begin
      state_d = ST_IDLE;
      valid_d = 2'b00;
      rd_en_d = 1'b0;
      wr_en_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rd_en_q      <= 1'b0;
      addr_q       <= '0;
      iss_col_q    <= '0;
      wr_en_q      <= 1'b0;
      wr_col_q     <= '0;
      fill_row_q   <= '0;
      valid_q      <= 2'b00;
      tag_q        <= '0;
      y_prev_q     <= '0;
      row_bg_q     <= 1'b0;
      underrun_q   <= 1'b0;
      pix_sel_q    <= 1'b0;
      line_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_en_q      <= rd_en_d;
      addr_q       <= addr_d;
      iss_col_q    <= iss_col_d;
      wr_en_q      <= wr_en_d;
      wr_col_q     <= wr_col_d;
      fill_row_q   <= fill_row_d;
      valid_q      <= valid_d;
      tag_q        <= tag_d;
      y_prev_q     <= y_addr;
      row_bg_q     <= row_bg_d;
      underrun_q   <= underrun_d;
      pix_sel_q    <= pix_sel_d;
      line_ready_q <= line_ready_d;
    end
  end

  line_buffer_pp #(
    .W      (W),
    .DATA_W (12),
    .COL_W  (COL_W)
  ) u_line_buffer_pp (
    .clk     (clk),
    .wr_en   (wr_en_q),
    .wr_bank (fill_row_q[0]),
    .wr_col  (wr_col_q),
    .wr_data (spram_rd_data),
    .rd_en   (buf_rd_en),
    .rd_bank (disp_bank),
    .rd_col  (disp_col),
    .rd_data (buf_rd_data)
  );

  assign spram_addr  = addr_q;
  assign spram_rd_en = rd_en_q;
  assign pixel_data  = pix_sel_q ? buf_rd_data : BG_COLOR;
  assign line_ready  = line_ready_q;
  assign underrun    = underrun_q;
  assign busy        = (state_q != ST_IDLE) && (state_q != ST_WAIT_LINE);

endmodule

`default_nettype wire

// File: tb/tb_frame_line_reader.sv
// ---------------------------------------------------------------------------
// tb_frame_line_reader : directed bench for frame_line_reader
// Revision             : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_frame_line_reader;

  logic        clk;
  logic        rst;
  logic        image_complete;
  logic        frame_start;
  logic [9:0]  x_addr;
  logic [9:0]  y_addr;
  logic [14:0] spram_addr;
  logic        spram_rd_en;
  logic [11:0] spram_rd_data;
  logic [11:0] pixel_data;
  logic        line_ready;
  logic        underrun;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int mon_exp  = 0;
  int mon_cnt  = 0;
  int mon_last = -1;
  int mon_bad  = 0;
  int busy_cnt = 0;

  typedef struct {
    int x;
    int y;
    int pix;
    int lr;
  } vec_t;
  vec_t vecs [8];

  frame_line_reader dut (
    .clk            (clk),
    .rst            (rst),
    .image_complete (image_complete),
    .frame_start    (frame_start),
    .x_addr         (x_addr),
    .y_addr         (y_addr),
    .spram_addr     (spram_addr),
    .spram_rd_en    (spram_rd_en),
    .spram_rd_data  (spram_rd_data),
    .pixel_data     (pixel_data),
    .line_ready     (line_ready),
    .underrun       (underrun),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SPRAM model: one-cycle read latency, data equals the low 12 address bits.
  always @(posedge clk) begin
    if (spram_rd_en) spram_rd_data <= spram_addr[11:0];
  end

  always begin
    @(posedge clk);
    #1;
    if (busy) busy_cnt++;
    if (spram_rd_en) begin
      if (int'(spram_addr) != mon_exp) mon_bad++;
      mon_exp++;
      mon_cnt++;
      mon_last = int'(spram_addr);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic pulse_fs();
    @(negedge clk);
    frame_start = 1'b1;
    mon_exp     = 0;
    mon_cnt     = 0;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic scan_row(input string name, input int y, input int base, input bit bg);
    int bad;
    int exp;
    bad = 0;
    @(negedge clk);
    y_addr = 10'(y);
    for (int i = 0; i < 200; i++) begin
      x_addr = 10'(300 + i);
      @(negedge clk);
      exp = bg ? 0 : ((base + i) & 12'hFFF);
      if (int'(pixel_data) != exp) begin
        if (bad == 0) $display("  %s first bad x=%0d got=%0d want=%0d", name, 300 + i, pixel_data, exp);
        bad++;
      end
    end
    x_addr = 10'd0;
    chk(name, bad, 0);
  endtask

  initial begin
    vecs[0] = '{x: 299, y: 225, pix: 0,   lr: 0};
    vecs[1] = '{x: 300, y: 225, pix: 200, lr: 1};
    vecs[2] = '{x: 499, y: 225, pix: 399, lr: 1};
    vecs[3] = '{x: 500, y: 225, pix: 0,   lr: 0};
    vecs[4] = '{x: 350, y: 223, pix: 0,   lr: 0};
    vecs[5] = '{x: 350, y: 225, pix: 250, lr: 1};
    vecs[6] = '{x: 350, y: 374, pix: 0,   lr: 0};
    vecs[7] = '{x: 351, y: 225, pix: 251, lr: 1};

    rst            = 1'b1;
    image_complete = 1'b0;
    frame_start    = 1'b0;
    x_addr         = 10'd0;
    y_addr         = 10'd0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rd_en", int'(spram_rd_en), 0);
    chk("rst_addr", int'(spram_addr), 0);
    chk("rst_pixel", int'(pixel_data), 0);
    chk("rst_line_ready", int'(line_ready), 0);
    chk("rst_underrun", int'(underrun), 0);
    chk("rst_busy", int'(busy), 0);

    // Prefetch of row 0
    image_complete = 1'b1;
    @(negedge clk);
    frame_start = 1'b1;
    mon_exp  = 0;
    mon_cnt  = 0;
    busy_cnt = 0;
    @(negedge clk);
    frame_start = 1'b0;
    chk("prefetch_first_en", int'(spram_rd_en), 1);
    chk("prefetch_first_addr", int'(spram_addr), 0);
    repeat (210) @(negedge clk);
    chk("prefetch_reads", mon_cnt, 200);
    chk("prefetch_last_addr", mon_last, 199);
    chk("prefetch_seq", mon_bad, 0);
    chk("prefetch_busy_cycles", busy_cnt, 201);
    chk("prefetch_wait_line", int'(busy), 0);

    scan_row("row224", 224, 0, 1'b0);
    repeat (10) @(negedge clk);
    chk("row1_reads", mon_cnt, 400);
    chk("row1_last_addr", mon_last, 399);
    chk("row1_idle", int'(busy), 0);

    scan_row("row225", 225, 200, 1'b0);
    repeat (10) @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      x_addr = 10'(vecs[v].x);
      y_addr = 10'(vecs[v].y);
      @(negedge clk);
      chk($sformatf("vec%0d_pixel", v), int'(pixel_data), vecs[v].pix);
      chk($sformatf("vec%0d_line_ready", v), int'(line_ready), vecs[v].lr);
    end
    x_addr = 10'd0;
    chk("window_no_underrun", int'(underrun), 0);

    for (int r = 2; r < 149; r++) begin
      @(negedge clk);
      y_addr = 10'(224 + r);
      repeat (205) @(negedge clk);
    end
    scan_row("row373", 373, 29800, 1'b0);
    repeat (5) @(negedge clk);
    chk("frame_reads", mon_cnt, 30000);
    chk("frame_last_addr", mon_last, 29999);
    chk("frame_seq", mon_bad, 0);
    chk("done_rd_en", int'(spram_rd_en), 0);
    chk("done_busy", int'(busy), 1);
    chk("frame_no_underrun", int'(underrun), 0);

    // Underrun: enter row 225 while row 1 is still filling
    @(negedge clk);
    y_addr = 10'd0;
    pulse_fs();
    repeat (210) @(negedge clk);
    chk("underrun_pre", int'(underrun), 0);
    @(negedge clk);
    y_addr = 10'd224;
    repeat (30) @(negedge clk);
    scan_row("underrun_row_bg", 225, 0, 1'b1);
    chk("underrun_flag", int'(underrun), 1);

    // Abort at fill index 120
    @(negedge clk);
    y_addr      = 10'd0;
    frame_start = 1'b1;
    mon_exp     = 0;
    mon_cnt     = 0;
    @(negedge clk);
    frame_start = 1'b0;
    chk("fs_clears_underrun", int'(underrun), 0);
    chk("restart_addr", int'(spram_addr), 0);
    repeat (120) @(negedge clk);
    chk("fill_idx120", int'(spram_addr), 120);
    frame_start = 1'b1;
    mon_exp     = 0;
    mon_cnt     = 0;
    @(negedge clk);
    frame_start = 1'b0;
    chk("abort_rd_en", int'(spram_rd_en), 1);
    chk("abort_addr", int'(spram_addr), 0);
    repeat (210) @(negedge clk);
    chk("abort_refill_reads", mon_cnt, 200);
    chk("abort_seq", mon_bad, 0);
    chk("abort_wait_line", int'(busy), 0);

    // Reset mid-fill
    pulse_fs();
    repeat (50) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_rd_en", int'(spram_rd_en), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_addr", int'(spram_addr), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_no_read", int'(spram_rd_en), 0);

    // image_complete falling mid-fill
    pulse_fs();
    repeat (30) @(negedge clk);
    image_complete = 1'b0;
    @(negedge clk);
    chk("imgc_fall_rd_en", int'(spram_rd_en), 0);
    chk("imgc_fall_busy", int'(busy), 0);
    chk("final_seq", mon_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
